// File: rtl/uart_rx_history.sv
// 8N1 UART transmitter and receiver with a shift register holding
// the most recently received characters (newest in the low byte).
module uart_rx_history #(
   parameter int DATA_WIDTH      = 8,
   parameter int BAUD_RATE       = 115_200,
   parameter int CLK_FREQ        = 50_000_000,
   parameter int CHARACTER_COUNT = 10
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  ena,
   output logic                                  tx_signal,
   input  logic [DATA_WIDTH-1:0]                 tx_data,
   input  logic                                  tx_valid,
   output logic                                  tx_ready,
   input  logic                                  rx_signal,
   output logic [DATA_WIDTH-1:0]                 rx_data,
   output logic                                  rx_valid,
   input  logic                                  rx_ready,
   output logic [DATA_WIDTH*CHARACTER_COUNT-1:0] sr_data
);

   localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
   localparam int CW      = $clog2(BIT_CYC);
   localparam int IW      = $clog2(DATA_WIDTH);
   localparam int SW      = DATA_WIDTH * CHARACTER_COUNT;

   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYC / 2);
   localparam logic [IW-1:0] BIT_LAST = IW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                tx_state;
   logic [CW-1:0]         tx_cnt;
   logic [IW-1:0]         tx_idx;
   logic [DATA_WIDTH-1:0] tx_shift;

   state_t                rx_state;
   logic [CW-1:0]         rx_cnt;
   logic [IW-1:0]         rx_idx;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic                  rx_s1;
   logic                  rx_s2;
   logic                  rx_valid_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state  <= IDLE;
         tx_cnt    <= '0;
         tx_idx    <= '0;
         tx_shift  <= '0;
         tx_signal <= 1'b1;
         tx_ready  <= 1'b1;
      end else if (ena) begin
         unique case (tx_state)
            IDLE: begin
               if (tx_valid && tx_ready) begin
                  tx_shift  <= tx_data;
                  tx_signal <= 1'b0;
                  tx_ready  <= 1'b0;
                  tx_cnt    <= '0;
                  tx_state  <= START;
               end
            end
            START: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt    <= '0;
                  tx_idx    <= '0;
                  tx_signal <= tx_shift[0];
                  tx_shift  <= tx_shift >> 1;
                  tx_state  <= DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            DATA: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_idx == BIT_LAST) begin
                     tx_signal <= 1'b1;
                     tx_state  <= STOP;
                  end else begin
                     tx_idx    <= tx_idx + 1'b1;
                     tx_signal <= tx_shift[0];
                     tx_shift  <= tx_shift >> 1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            STOP: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt   <= '0;
                  tx_ready <= 1'b1;
                  tx_state <= IDLE;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // Sync flops idle high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_state   <= IDLE;
         rx_cnt     <= '0;
         rx_idx     <= '0;
         rx_shift   <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_valid_d <= 1'b0;
         sr_data    <= '0;
      end else if (ena) begin
         rx_s1      <= rx_signal;
         rx_s2      <= rx_s1;
         rx_valid_d <= rx_valid;
         if (rx_valid && !rx_valid_d)
            sr_data <= {sr_data[SW-DATA_WIDTH-1:0], rx_data};
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;
         unique case (rx_state)
            IDLE: begin
               if (!rx_s2) begin
                  rx_cnt   <= '0;
                  rx_state <= START;
               end
            end
            START: begin
               if (rx_cnt == CNT_HALF) begin
                  rx_cnt   <= '0;
                  rx_idx   <= '0;
                  rx_state <= rx_s2 ? IDLE : DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            DATA: begin
               if (rx_cnt == CNT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s2, rx_shift[DATA_WIDTH-1:1]};
                  if (rx_idx == BIT_LAST)
                     rx_state <= STOP;
                  else
                     rx_idx <= rx_idx + 1'b1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            STOP: begin
               if (rx_cnt == CNT_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= IDLE;
                  // Bad stop bit or unconsumed previous byte: drop it.
                  if (rx_s2 && !rx_valid) begin
                     rx_data  <= rx_shift;
                     rx_valid <= 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_history.sv
// Self-checking bench for uart_rx_history: loopback, history order,
// handshake/overrun, bit timing, enable freeze, framing error and reset.
module tb_uart_rx_history;

   localparam int BIT_CYC = 434;
   localparam int CC      = 10;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ena = 1'b1;
   logic        tx_signal;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic        rx_signal;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic [79:0] sr_data;
   logic        loop_en = 1'b1;
   logic        rx_drv = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [7:0] hist[$];
   logic       lvl[6000];

   assign rx_signal = loop_en ? tx_signal : rx_drv;

   always #5 clk = ~clk;

   uart_rx_history dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ena       (ena),
      .tx_signal (tx_signal),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_signal (rx_signal),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .sr_data   (sr_data)
   );

   function automatic void model_rx(input logic [7:0] b);
      hist.push_front(b);
      if (hist.size() > CC) void'(hist.pop_back());
   endfunction

   function automatic logic [79:0] exp_sr();
      logic [79:0] r = '0;
      foreach (hist[i]) r[i*8 +: 8] = hist[i];
      return r;
   endfunction

   task automatic send(input logic [7:0] b, output int low, output bit ok);
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      low = 0;
      ok  = 1'b0;
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         if (tx_ready) begin
            ok = 1'b1;
            break;
         end
         low++;
      end
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (BIT_CYC) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         rx_drv = b[k];
         repeat (BIT_CYC) @(negedge clk);
      end
      rx_drv = stop;
      repeat (stop ? BIT_CYC : 300) @(negedge clk);
      rx_drv = 1'b1;
      repeat (BIT_CYC) @(negedge clk);
   endtask

   task automatic loop_byte(input logic [7:0] b);
      int low;
      bit ok;
      send(b, low, ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL tx_done got %0d want 1", ok);
      end
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== b) begin
         errors++;
         $display("FAIL rx_byte got v=%b d=%h want v=1 d=%h",
                  rx_valid, rx_data, b);
      end
      model_rx(b);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      checks++;
      if (rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL rx_consume got %b want 0", rx_valid);
      end
      checks++;
      if (sr_data !== exp_sr() || sr_data[7:0] !== b) begin
         errors++;
         $display("FAIL sr_after got %h want %h", sr_data, exp_sr());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_signal, tx_ready, rx_valid} !== 3'b110 ||
          rx_data !== 8'h00 || sr_data !== 80'h0) begin
         errors++;
         $display("FAIL reset_held got tx=%b rdy=%b v=%b d=%h sr=%h want 1 1 0 00 0",
                  tx_signal, tx_ready, rx_valid, rx_data, sr_data);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({tx_signal, tx_ready, rx_valid} !== 3'b110 || sr_data !== 80'h0) begin
         errors++;
         $display("FAIL reset_idle got tx=%b rdy=%b v=%b sr=%h want 1 1 0 0",
                  tx_signal, tx_ready, rx_valid, sr_data);
      end
   endtask

   task automatic test_history();
      loop_byte(8'h41);
      loop_byte(8'h42);
      loop_byte(8'h43);
      checks++;
      if (sr_data[23:0] !== 24'h414243 || sr_data[79:24] !== 56'h0) begin
         errors++;
         $display("FAIL history_order got %h want 00..00414243", sr_data);
      end
   endtask

   task automatic test_loopback();
      loop_byte(8'h00);
      loop_byte(8'hFF);
      for (int i = 0; i < 3; i++)
         loop_byte(8'($urandom_range(0, 255)));
   endtask

   task automatic test_timing();
      logic [7:0] b = 8'h55;
      logic [9:0] fr;
      int low;
      int bad;
      fr = {1'b1, b, 1'b0};
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      low = 0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (tx_ready) break;
         lvl[low] = tx_signal;
         low++;
      end
      checks++;
      if (low != 10 * BIT_CYC) begin
         errors++;
         $display("FAIL tx_ready_low got %0d want %0d", low, 10 * BIT_CYC);
      end
      for (int k = 0; k < 10; k++) begin
         bad = 0;
         for (int j = 0; j < BIT_CYC; j++)
            if (k * BIT_CYC + j >= low || lvl[k * BIT_CYC + j] !== fr[k])
               bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL bit_%0d got %0d wrong cycles want level %b for %0d",
                     k, bad, fr[k], BIT_CYC);
         end
      end
      checks++;
      if (tx_signal !== 1'b1 || rx_valid !== 1'b1 || rx_data !== b) begin
         errors++;
         $display("FAIL timing_end got tx=%b v=%b d=%h want 1 1 %h",
                  tx_signal, rx_valid, rx_data, b);
      end
      model_rx(b);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic test_handshake();
      logic [7:0] a = 8'($urandom_range(0, 255));
      logic [7:0] b;
      int drops = 0;
      int low;
      bit ok;
      b = a ^ 8'h5A;
      send(a, low, ok);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== a) begin
         errors++;
         $display("FAIL hs_first got v=%b d=%h want 1 %h", rx_valid, rx_data, a);
      end
      model_rx(a);
      for (int i = 0; i < 5 * BIT_CYC + 130; i++) begin
         @(negedge clk);
         if (rx_valid !== 1'b1) drops++;
      end
      checks++;
      if (drops != 0) begin
         errors++;
         $display("FAIL hs_hold got %0d low cycles want 0", drops);
      end
      send(b, low, ok);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== a || sr_data !== exp_sr()) begin
         errors++;
         $display("FAIL overrun got v=%b d=%h sr=%h want 1 %h %h",
                  rx_valid, rx_data, sr_data, a, exp_sr());
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      checks++;
      if (rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL hs_drop got %b want 0", rx_valid);
      end
   endtask

   task automatic test_ena();
      logic [7:0] b = 8'($urandom_range(0, 255));
      logic held = 1'b0;
      int moved = 0;
      int n;
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      for (n = 1; n <= 8000; n++) begin
         @(negedge clk);
         if (tx_ready) break;
         if (n > 2000 && n <= 3000 && tx_signal !== held) moved++;
         if (n == 2000) begin
            ena  = 1'b0;
            held = tx_signal;
         end
         if (n == 3000) ena = 1'b1;
      end
      checks++;
      if (moved != 0) begin
         errors++;
         $display("FAIL ena_freeze got %0d changes want 0", moved);
      end
      checks++;
      if (n != 10 * BIT_CYC + 1000 + 1) begin
         errors++;
         $display("FAIL ena_len got %0d want %0d", n - 1, 10 * BIT_CYC + 1000);
      end
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== b) begin
         errors++;
         $display("FAIL ena_rx got v=%b d=%h want 1 %h", rx_valid, rx_data, b);
      end
      model_rx(b);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic test_framing();
      logic [7:0] c = 8'($urandom_range(0, 255));
      loop_en = 1'b0;
      drive_frame(8'hA5, 1'b0);
      repeat (500) @(negedge clk);
      checks++;
      if (rx_valid !== 1'b0 || sr_data !== exp_sr()) begin
         errors++;
         $display("FAIL framing got v=%b sr=%h want 0 %h",
                  rx_valid, sr_data, exp_sr());
      end
      rx_drv = 1'b0;
      repeat (50) @(negedge clk);
      rx_drv = 1'b1;
      repeat (5000) @(negedge clk);
      checks++;
      if (rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL glitch got %b want 0", rx_valid);
      end
      drive_frame(c, 1'b1);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== c) begin
         errors++;
         $display("FAIL manual_rx got v=%b d=%h want 1 %h", rx_valid, rx_data, c);
      end
      model_rx(c);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (sr_data !== exp_sr()) begin
         errors++;
         $display("FAIL manual_sr got %h want %h", sr_data, exp_sr());
      end
      loop_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      tx_data  = 8'($urandom_range(0, 255));
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      repeat (1500) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({tx_signal, tx_ready, rx_valid} !== 3'b110 ||
          rx_data !== 8'h00 || sr_data !== 80'h0) begin
         errors++;
         $display("FAIL reset_mid got tx=%b rdy=%b v=%b d=%h sr=%h want 1 1 0 00 0",
                  tx_signal, tx_ready, rx_valid, rx_data, sr_data);
      end
      hist.delete();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      loop_byte(8'h5A);
   endtask

   initial begin
      test_reset();
      test_history();
      test_loopback();
      test_timing();
      test_handshake();
      test_ena();
      test_framing();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
